// File: rtl/rosc_pkg.sv
// rosc_pkg: constants and FSM state type shared by the ring-oscillator
// frequency meter and its per-channel slice.
//   SETTLE_CYC   : clk cycles the rings run before the counting window opens
//   rosc_state_e : measurement sequencer states
package rosc_pkg;

    localparam int unsigned SETTLE_CYC = 8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StCount  = 2'd2,
        StLatch  = 2'd3
    } rosc_state_e;

endpackage

// File: rtl/rosc_chan.sv
// rosc_chan: one measurement channel.
//   Ring oscillator (NAND enable stage + STAGES-1 inverters) or test input,
//   ring-domain prescaler, 3-flop synchronizer with rising-edge detect, and a
//   saturating edge counter in the clk domain.
// Ports:
//   clk_i, rst_ni   : system clock, asynchronous active-low reset
//   ring_en_i       : runs the ring and releases the prescaler
//   test_mode_i     : 1 selects test_osc_i instead of the ring
//   test_osc_i      : external oscillator substitute
//   clr_i           : synchronous clear of counter and overflow flag
//   count_en_i      : counting window open
//   cnt_o, ovf_o    : edge count and saturation flag
module rosc_chan #(
    parameter int unsigned STAGES     = 1001,
    parameter int unsigned PRESC_BITS = 4,
    parameter int unsigned COUNT_W    = 24,
    parameter bit          RING_MODEL = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               ring_en_i,
    input  logic               test_mode_i,
    input  logic               test_osc_i,
    input  logic               clr_i,
    input  logic               count_en_i,
    output logic [COUNT_W-1:0] cnt_o,
    output logic               ovf_o
);

    localparam logic [COUNT_W-1:0] CntMax = {COUNT_W{1'b1}};

    logic                  ring_out;
    logic                  osc_src;
    logic                  presc_clr_n;
    logic [PRESC_BITS-1:0] presc_q;
    logic                  sync1_q, sync2_q, sync3_q;
    logic                  rise;
    logic [COUNT_W-1:0]    cnt_q;
    logic                  ovf_q;

    // Prescaler is held in reset whenever the ring is parked.
    assign presc_clr_n = rst_ni & ring_en_i;

    if (RING_MODEL) begin : g_ring_model
        // Cycle-based stand-in for the ring: toggles at clk/2 while enabled, so
        // the rest of the channel can be exercised without a combinational loop.
        logic tog_q;
        always_ff @(posedge clk_i or negedge presc_clr_n) begin
            if (!presc_clr_n) begin
                tog_q <= 1'b0;
            end else begin
                tog_q <= ~tog_q;
            end
        end
        assign ring_out = tog_q;
    end else begin : g_ring
        // Stage 0 is the enable NAND: forced to 1 while ring_en_i=0, which
        // leaves the whole chain static. The odd total inversion count makes
        // the loop oscillate once enabled.
        (* keep = "true" *) logic [STAGES-1:0] node;
        assign node[0] = ~(node[STAGES-1] & ring_en_i);
        for (genvar k = 1; k < STAGES; k++) begin : g_stage
            assign node[k] = ~node[k-1];
        end
        assign ring_out = node[STAGES-1];
    end

    assign osc_src = test_mode_i ? test_osc_i : ring_out;

    always_ff @(posedge osc_src or negedge presc_clr_n) begin
        if (!presc_clr_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // Prescaler MSB crosses into clk through two flops; the third flop gives
    // the previous value for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= presc_q[PRESC_BITS-1];
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign rise = sync2_q & ~sync3_q;

    // Saturating counter: an edge arriving at full scale flags overflow
    // instead of wrapping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (clr_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (count_en_i && rise) begin
            if (cnt_q == CntMax) begin
                ovf_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/rosc_freq_meter.sv
// rosc_freq_meter: multi-channel ring-oscillator frequency meter.
//   A start request with a non-zero gate length runs the rings for SETTLE_CYC
//   cycles, counts prescaled oscillator edges for gate_len cycles, then
//   registers the per-channel results and pulses done.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   start       : measurement request (ignored while busy or gate_len==0)
//   gate_len    : counting window in clk cycles, captured on acceptance
//   test_mode   : 1 measures test_osc instead of the rings
//   test_osc    : external oscillator substitutes, one per channel
//   busy        : measurement in progress
//   done        : one-cycle pulse when count/ovf have been updated
//   count       : channel i result at [i*COUNT_W +: COUNT_W]
//   ovf         : per-channel saturation flag
module rosc_freq_meter
    import rosc_pkg::*;
#(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned STAGES     = 1001,
    parameter int unsigned PRESC_BITS = 4,
    parameter int unsigned GATE_BITS  = 20,
    parameter int unsigned COUNT_W    = 24,
    parameter bit          RING_MODEL = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [GATE_BITS-1:0]        gate_len,
    input  logic                        test_mode,
    input  logic [CHANNELS-1:0]         test_osc,
    output logic                        busy,
    output logic                        done,
    output logic [CHANNELS*COUNT_W-1:0] count,
    output logic [CHANNELS-1:0]         ovf
);

    localparam logic [GATE_BITS-1:0] SettleLast = GATE_BITS'(SETTLE_CYC - 1);
    localparam logic [GATE_BITS-1:0] GateOne    = GATE_BITS'(1);

    rosc_state_e                 state_q, state_d;
    logic [GATE_BITS-1:0]        gate_q, gate_d;
    logic [GATE_BITS-1:0]        timer_q, timer_d;
    logic                        ring_en_q, ring_en_d;
    logic                        done_q, done_d;
    logic [CHANNELS*COUNT_W-1:0] count_q;
    logic [CHANNELS-1:0]         ovf_q;
    logic [CHANNELS*COUNT_W-1:0] chan_cnt;
    logic [CHANNELS-1:0]         chan_ovf;
    logic                        cnt_clr, cnt_en, capture;

    // timer_q counts down the remaining cycles of SETTLE and COUNT.
    always_comb begin
        state_d   = state_q;
        gate_d    = gate_q;
        timer_d   = timer_q;
        ring_en_d = ring_en_q;
        done_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start && (gate_len != '0)) begin
                    state_d   = StSettle;
                    gate_d    = gate_len;
                    timer_d   = SettleLast;
                    ring_en_d = 1'b1;
                end
            end
            StSettle: begin
                if (timer_q == '0) begin
                    state_d = StCount;
                    timer_d = gate_q - GateOne;
                end else begin
                    timer_d = timer_q - GateOne;
                end
            end
            StCount: begin
                if (timer_q == '0) begin
                    state_d   = StLatch;
                    ring_en_d = 1'b0;
                end else begin
                    timer_d = timer_q - GateOne;
                end
            end
            StLatch: begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
            default: begin
                state_d   = StIdle;
                ring_en_d = 1'b0;
            end
        endcase
    end

    assign cnt_clr = (state_q == StSettle);
    assign cnt_en  = (state_q == StCount);
    assign capture = (state_q == StLatch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            gate_q    <= '0;
            timer_q   <= '0;
            ring_en_q <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= '0;
            ovf_q     <= '0;
        end else begin
            state_q   <= state_d;
            gate_q    <= gate_d;
            timer_q   <= timer_d;
            ring_en_q <= ring_en_d;
            done_q    <= done_d;
            if (capture) begin
                count_q <= chan_cnt;
                ovf_q   <= chan_ovf;
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        rosc_chan #(
            .STAGES     (STAGES),
            .PRESC_BITS (PRESC_BITS),
            .COUNT_W    (COUNT_W),
            .RING_MODEL (RING_MODEL)
        ) u_chan (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .ring_en_i   (ring_en_q),
            .test_mode_i (test_mode),
            .test_osc_i  (test_osc[i]),
            .clr_i       (cnt_clr),
            .count_en_i  (cnt_en),
            .cnt_o       (chan_cnt[i*COUNT_W +: COUNT_W]),
            .ovf_o       (chan_ovf[i])
        );
    end

    assign busy  = (state_q != StIdle);
    assign done  = done_q;
    assign count = count_q;
    assign ovf   = ovf_q;

endmodule
